// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM with byte-lane stores, fixed wait states and a pipeline stall request.
// DMEM_WAIT_EN selects the IDLE/WAIT/DONE access FSM; when undefined, the RAM responds combinationally with no stall.
module data_mem_resp #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        err_o
);

    logic [31:0] ram [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_oor;
    logic                  unused_byte_offset;

    assign req_idx            = mem_addr_i[ADDR_WIDTH+1:2];
    assign req_oor            = |mem_addr_i[31:ADDR_WIDTH+2];
    assign unused_byte_offset = ^mem_addr_i[1:0];

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [3:0]            wr_sel;
    logic [31:0]           wr_data;

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state, next_state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  oor_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_oor;
    logic                  rd_we;

    assign accept = (state == IDLE) && mem_ce_i;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (mem_ce_i) next_state = (WAIT_CYCLES > 0) ? WAIT : DONE;
            WAIT: begin
                if (!mem_ce_i)         next_state = IDLE;
                else if (cnt <= 4'd1)  next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        case (state)
            IDLE:    stallreq_o = mem_ce_i;
            WAIT:    stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
        err_o      = (state == DONE) && oor_q;
        mem_data_o = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst)                cnt <= 4'd0;
        else if (accept)        cnt <= 4'(WAIT_CYCLES);
        else if (state == WAIT) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            oor_q   <= req_oor;
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            wdata_q <= mem_data_i;
        end
    end

    // With zero wait states DONE is entered straight from IDLE, before the latch holds the request.
    assign rd_idx = (state == IDLE) ? req_idx  : idx_q;
    assign rd_oor = (state == IDLE) ? req_oor  : oor_q;
    assign rd_we  = (state == IDLE) ? mem_we_i : we_q;

    // Holds zero outside DONE, so the output needs no further gating.
    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= 32'd0;
        else if (next_state == DONE && !rd_we && !rd_oor)
            rdata_q <= ram[rd_idx];
        else
            rdata_q <= 32'd0;
    end

    assign wr_en   = !rst && (state == DONE) && we_q && !oor_q;
    assign wr_idx  = idx_q;
    assign wr_sel  = sel_q;
    assign wr_data = wdata_q;
`else
    logic [3:0] unused_wait_cycles;

    assign unused_wait_cycles = 4'(WAIT_CYCLES);
    assign stallreq_o         = 1'b0;
    assign err_o              = mem_ce_i && req_oor;
    assign mem_data_o         = (mem_ce_i && !mem_we_i && !req_oor) ? ram[req_idx] : 32'd0;

    assign wr_en   = !rst && mem_ce_i && mem_we_i && !req_oor;
    assign wr_idx  = req_idx;
    assign wr_sel  = mem_sel_i;
    assign wr_data = mem_data_i;
`endif

    // No reset on the array: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel[b]) ram[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp (default parameters), covering whichever DMEM_WAIT_EN build is compiled.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        err_o;

    int pass_cnt = 0;
    int total    = 0;

    data_mem_resp dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .stallreq_o (stallreq_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        mem_ce_i   = 1'b1;
        mem_we_i   = w;
        mem_addr_i = a;
        mem_sel_i  = s;
        mem_data_i = d;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        mem_ce_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({mem_data_o, stallreq_o, err_o} !== 34'd0)
                $display("FAIL reset_cycle%0d: data=%h stall=%b err=%b, need all 0", i, mem_data_o, stallreq_o, err_o);
            else pass_cnt++;
        end
        rst = 1'b0;
        step();
    endtask

`ifdef DMEM_WAIT_EN
    // Runs one access to completion; n counts stalled cycles, q/e are sampled in the first unstalled cycle.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output int n, output logic [31:0] q, output logic e, output logic leak);
        drive(w, a, s, d);
        #1;
        n    = 0;
        leak = 1'b0;
        while (stallreq_o === 1'b1 && n < 40) begin
            if (mem_data_o !== 32'd0 || err_o !== 1'b0) leak = 1'b1;
            n++;
            step();
        end
        q        = mem_data_o;
        e        = err_o;
        mem_ce_i = 1'b0;
        mem_we_i = 1'b0;
        step();
    endtask

    task automatic test_store_load();
        int n; logic [31:0] q; logic e, leak;
        access(1'b1, 32'h40, 4'b1111, 32'h11223344, n, q, e, leak);
        total++; if (n !== 3) $display("FAIL store_stall_cycles: got %0d need 3", n); else pass_cnt++;
        access(1'b0, 32'h40, 4'b1111, 32'h0, n, q, e, leak);
        total++; if (n !== 3) $display("FAIL load_stall_cycles: got %0d need 3", n); else pass_cnt++;
        total++; if (q !== 32'h11223344) $display("FAIL load_data: got %h need 11223344", q); else pass_cnt++;
        total++; if (e !== 1'b0) $display("FAIL load_err: got %b need 0", e); else pass_cnt++;
        total++; if (leak !== 1'b0) $display("FAIL load_outputs_while_stalled: got nonzero need 0"); else pass_cnt++;
    endtask

    task automatic test_byte_store();
        int n; logic [31:0] q; logic e, leak;
        access(1'b1, 32'h40, 4'b0010, 32'h0000AB00, n, q, e, leak);
        access(1'b0, 32'h40, 4'b1111, 32'h0, n, q, e, leak);
        total++; if (q !== 32'h1122AB44) $display("FAIL byte_lane1: got %h need 1122ab44", q); else pass_cnt++;
        access(1'b1, 32'h40, 4'b1000, 32'h55000000, n, q, e, leak);
        access(1'b0, 32'h40, 4'b0001, 32'h0, n, q, e, leak);
        total++; if (q !== 32'h5522AB44) $display("FAIL byte_lane3: got %h need 5522ab44", q); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        int n; logic [31:0] q; logic e, leak;
        access(1'b1, 32'h0, 4'b1111, 32'hA5A5A5A5, n, q, e, leak);
        access(1'b0, 32'h00010000, 4'b1111, 32'h0, n, q, e, leak);
        total++; if (e !== 1'b1) $display("FAIL oor_load_err: got %b need 1", e); else pass_cnt++;
        total++; if (q !== 32'h0) $display("FAIL oor_load_data: got %h need 0", q); else pass_cnt++;
        access(1'b1, 32'h00010000, 4'b1111, 32'hFFFFFFFF, n, q, e, leak);
        total++; if (e !== 1'b1) $display("FAIL oor_store_err: got %b need 1", e); else pass_cnt++;
        access(1'b0, 32'h0, 4'b1111, 32'h0, n, q, e, leak);
        total++; if (q !== 32'hA5A5A5A5) $display("FAIL oor_store_suppressed: got %h need a5a5a5a5", q); else pass_cnt++;
        total++; if (e !== 1'b0) $display("FAIL inrange_err: got %b need 0", e); else pass_cnt++;
    endtask

    task automatic test_abort();
        int n; logic [31:0] q; logic e, leak;
        access(1'b1, 32'h80, 4'b1111, 32'h01020304, n, q, e, leak);
        drive(1'b1, 32'h80, 4'b1111, 32'hDEADBEEF);
        step();
        mem_ce_i = 1'b0;
        #1;
        total++; if (stallreq_o !== 1'b1) $display("FAIL abort_wait_stall: got %b need 1", stallreq_o); else pass_cnt++;
        step();
        total++; if (stallreq_o !== 1'b0) $display("FAIL abort_stall_falls: got %b need 0", stallreq_o); else pass_cnt++;
        total++; if (err_o !== 1'b0) $display("FAIL abort_err: got %b need 0", err_o); else pass_cnt++;
        step();
        access(1'b0, 32'h80, 4'b1111, 32'h0, n, q, e, leak);
        total++; if (q !== 32'h01020304) $display("FAIL abort_no_write: got %h need 01020304", q); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1'b0, 32'h40, 4'b1111, 32'h0);
        #1;
        n = 0;
        while (stallreq_o === 1'b1 && n < 40) begin n++; step(); end
        total++; if (mem_data_o !== 32'h5522AB44) $display("FAIL b2b_first_data: got %h need 5522ab44", mem_data_o); else pass_cnt++;
        mem_addr_i = 32'h0;
        step();
        total++; if (stallreq_o !== 1'b1) $display("FAIL b2b_new_accept_stall: got %b need 1", stallreq_o); else pass_cnt++;
        n = 0;
        while (stallreq_o === 1'b1 && n < 40) begin n++; step(); end
        total++; if (n !== 3) $display("FAIL b2b_second_stall_cycles: got %0d need 3", n); else pass_cnt++;
        total++; if (mem_data_o !== 32'hA5A5A5A5) $display("FAIL b2b_second_data: got %h need a5a5a5a5", mem_data_o); else pass_cnt++;
        mem_ce_i = 1'b0;
        step();
    endtask

    task automatic test_reset_midflight();
        int n; logic [31:0] q; logic e, leak;
        access(1'b1, 32'h100, 4'b1111, 32'h12345678, n, q, e, leak);
        drive(1'b1, 32'h100, 4'b1111, 32'h77777777);
        for (int i = 0; i < 3; i++) step();
        total++; if (stallreq_o !== 1'b0) $display("FAIL midrst_done_stall: got %b need 0", stallreq_o); else pass_cnt++;
        rst      = 1'b1;
        mem_ce_i = 1'b0;
        step();
        rst = 1'b0;
        total++; if ({mem_data_o, stallreq_o, err_o} !== 34'd0)
            $display("FAIL midrst_outputs: data=%h stall=%b err=%b need 0", mem_data_o, stallreq_o, err_o);
        else pass_cnt++;
        access(1'b0, 32'h100, 4'b1111, 32'h0, n, q, e, leak);
        total++; if (q !== 32'h12345678) $display("FAIL midrst_store_dropped: got %h need 12345678", q); else pass_cnt++;
    endtask
`else
    // One request cycle: outputs sampled combinationally, store commits at the closing edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] q, output logic e, output logic st);
        drive(w, a, s, d);
        #1;
        q  = mem_data_o;
        e  = err_o;
        st = stallreq_o;
        step();
        mem_ce_i = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] q; logic e, st;
        access(1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, q, e, st);
        total++; if (st !== 1'b0) $display("FAIL store_stall: got %b need 0", st); else pass_cnt++;
        total++; if (e !== 1'b0) $display("FAIL store_err: got %b need 0", e); else pass_cnt++;
        access(1'b0, 32'h10, 4'b1111, 32'h0, q, e, st);
        total++; if (q !== 32'hCAFEF00D) $display("FAIL load_data: got %h need cafef00d", q); else pass_cnt++;
        total++; if (st !== 1'b0) $display("FAIL load_stall: got %b need 0", st); else pass_cnt++;
    endtask

    task automatic test_byte_store();
        logic [31:0] q; logic e, st;
        access(1'b1, 32'h10, 4'b0010, 32'h0000AB00, q, e, st);
        access(1'b0, 32'h10, 4'b1111, 32'h0, q, e, st);
        total++; if (q !== 32'hCAFEAB0D) $display("FAIL byte_lane1: got %h need cafeab0d", q); else pass_cnt++;
        access(1'b1, 32'h10, 4'b1000, 32'h55000000, q, e, st);
        access(1'b0, 32'h10, 4'b0001, 32'h0, q, e, st);
        total++; if (q !== 32'h55FEAB0D) $display("FAIL byte_lane3: got %h need 55feab0d", q); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] q; logic e, st;
        access(1'b1, 32'h0, 4'b1111, 32'hA5A5A5A5, q, e, st);
        access(1'b0, 32'h00010000, 4'b1111, 32'h0, q, e, st);
        total++; if (e !== 1'b1) $display("FAIL oor_load_err: got %b need 1", e); else pass_cnt++;
        access(1'b1, 32'h00010000, 4'b1111, 32'hFFFFFFFF, q, e, st);
        total++; if (e !== 1'b1) $display("FAIL oor_store_err: got %b need 1", e); else pass_cnt++;
        access(1'b0, 32'h0, 4'b1111, 32'h0, q, e, st);
        total++; if (q !== 32'hA5A5A5A5) $display("FAIL oor_store_suppressed: got %h need a5a5a5a5", q); else pass_cnt++;
        total++; if (e !== 1'b0) $display("FAIL inrange_err: got %b need 0", e); else pass_cnt++;
    endtask

    task automatic test_idle_outputs();
        logic [31:0] q; logic e, st;
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h10;
        #1;
        total++; if (mem_data_o !== 32'h0) $display("FAIL idle_data: got %h need 0", mem_data_o); else pass_cnt++;
        access(1'b1, 32'h10, 4'b0000, 32'h0, q, e, st);
        total++; if (q !== 32'h0) $display("FAIL store_cycle_data: got %h need 0", q); else pass_cnt++;
        access(1'b0, 32'h10, 4'b1111, 32'h0, q, e, st);
        total++; if (q !== 32'h55FEAB0D) $display("FAIL sel0_store_no_write: got %h need 55feab0d", q); else pass_cnt++;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h0;
        mem_sel_i  = 4'h0;
        mem_data_i = 32'h0;
        test_reset();
        test_store_load();
        test_byte_store();
        test_out_of_range();
`ifdef DMEM_WAIT_EN
        test_abort();
        test_back_to_back();
        test_reset_midflight();
`else
        test_idle_outputs();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
